demo_split: RTL and testbench
=============================

Name: demo_split

Overview:
- Producer-side counterpart of the aligned accumulator: the accumulator folds 4-aligned values into a total; this block takes a total and splits it back into a stream of 4-aligned chunks.
- Accepts one WIDTH-bit total over a valid/ready handshake.
- Aligns the total down to a multiple of 4 by decrementing one per cycle, and reports the removed amount as `residual`.
- Emits the aligned remainder as chunks of at most CHUNK over a valid/ready output with a last flag.

Parameters:
- WIDTH, 8, data width of `in_data`, `out_data` and the internal remainder.
- CHUNK, 16, maximum beat value; must be a nonzero multiple of 4 and below 2**WIDTH.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  reset, asynchronous, active-low (0 = reset).
- in_valid  input  1  `in_data` valid.
- in_ready  output  1  block can accept a total.
- in_data  input  WIDTH  total to split.
- out_valid  output  1  chunk valid.
- out_ready  input  1  downstream accepts chunk.
- out_data  output  WIDTH  chunk value; bits [1:0] always 0.
- out_last  output  1  final chunk of the current total.
- residual  output  2  amount removed during alignment (`in_data` mod 4); valid while `out_valid`.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, ALIGN, EMIT. All outputs registered, except `in_ready` and `busy`, which decode the state.
- Reset (reset=0, async):
  - state=IDLE; rem=0; `out_valid`=0, `out_data`=0, `out_last`=0, `residual`=0.
  - `in_ready`=1 and `busy`=0 in IDLE.
  - Applies mid-operation: an in-flight total is discarded, with no further beats and no completion.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` & `in_ready`: rem<=`in_data`, res<=0, go to ALIGN.
- ALIGN:
  - `in_ready`=0.
  - If rem[1:0]!=0: rem<=rem-1, res<=res+1, stay.
  - Else: go to EMIT and load the first beat.
  - Occupancy is k+1 cycles, where k=`in_data`[1:0]. `out_valid` rises k+1 edges after the accepting edge.
- Beat load:
  - `out_data` <= min(rem, CHUNK).
  - `out_last` <= (rem <= CHUNK).
  - `out_valid` <= 1.
  - `residual` <= res.
- EMIT:
  - `out_valid`=1. `out_data`, `out_last` and `residual` are held stable while `out_ready`=0 (stall of any length).
  - On `out_valid` & `out_ready` with `out_last`=0: rem <= rem-`out_data`, load the next beat on the same edge. Back-to-back beats, no bubble.
  - On `out_valid` & `out_ready` with `out_last`=1: `out_valid`<=0, `out_last`<=0, go to IDLE. The next total can be accepted on the following cycle.
- Zero case: an aligned total of 0 (`in_data` 0..3) emits exactly one beat, `out_data`=0, `out_last`=1.
- Invariants:
  - Sum of beats = `in_data` - `residual`.
  - Beat count = max(1, ceil((`in_data` & ~3)/CHUNK)).
  - `out_data`[1:0]==0.
- Arithmetic: WIDTH-bit unsigned. No wrap is possible: rem only decreases and is never decremented below 0.
- `in_valid` while not in IDLE is ignored; `in_data` is not sampled.

Optional Feature:
- Macro: DEMO_SPLIT_ASSERT_EN.
- With the macro defined, embedded clocked assertions are compiled in, all gated by reset=1:
  - `out_valid` -> `out_data`[1:0]==0 and `out_data`<=CHUNK.
  - `out_valid` & !`out_ready` -> next cycle `out_data`, `out_last` and `residual` unchanged and `out_valid` still 1.
  - State never leaves the encoded set.
  - Running beat sum equals the aligned total when the `out_last` beat handshakes.
- Without the macro: no assertion code. Functional RTL is identical.

Decomposition:
- Package demo_pkg:
  - state enum typedef (IDLE, ALIGN, EMIT).
  - ALIGN_MASK = 2'b11 constant.
  - Shared with the accumulator for its state encoding.
- No sub-module: the min(rem, CHUNK) beat selection stays inline. Whole block is a single module.

Test Plan:
- `in_data`=6, `out_ready`=1 -> ALIGN 3 cycles; one beat `out_data`=4, `out_last`=1, `residual`=2; `busy` drops after handshake.
- `in_data`=40 -> `out_valid` 1 edge after accept; beats 16,16,8 on consecutive cycles; `out_last` only on 8; `residual`=0.
- `in_data`=0 and `in_data`=3 -> single beat 0, `out_last`=1; `residual` 0 and 3 respectively.
- `in_data`=255, `out_ready` low 5 cycles at beat 1 -> `out_data`=16 held stable throughout; 15 beats of 16 then 12 with last; `residual`=3.
- reset=0 for 2 cycles during beat 2 of `in_data`=40 -> `out_valid`=0 immediately (async), `in_ready`=1 after release; then `in_data`=4 -> single beat 4, last, `residual` 0.
- `in_valid`=1 with `in_data`=100 held during an active split of 40 -> ignored (`in_ready`=0); accepted the cycle after the 40 total's last handshake.

Source files
------------

// File: rtl/demo_pkg.sv
// rtl/demo_pkg.sv - shared state encoding and alignment constant for the split/accumulate pair
package demo_pkg;

  // The accumulator uses the same encoding, so keep these values fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // Low bits that must be clear for a value to be 4-aligned.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/demo_split.sv
// rtl/demo_split.sv - splits a total into 4-aligned chunks of at most CHUNK; DEMO_SPLIT_ASSERT_EN adds embedded assertions
module demo_split
  import demo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       residual,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CHUNK_W = WIDTH'(CHUNK);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] rem_q;
  logic [1:0]       res_q;

  // rem_q still includes the beat currently presented; rem_sub is what is left after it.
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] beat_src;
  logic [WIDTH-1:0] beat_data;
  logic             beat_last;
  logic             misaligned;

  // Beat selection: first beat comes from the aligned remainder, later beats from what is left.
  always_comb begin
    rem_sub    = rem_q - out_data;
    beat_src   = (state_q == EMIT) ? rem_sub : rem_q;
    beat_data  = (beat_src > CHUNK_W) ? CHUNK_W : beat_src;
    beat_last  = (beat_src <= CHUNK_W);
    misaligned = ((rem_q[1:0] & ALIGN_MASK) != 2'b00);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ALIGN;
      ALIGN:   if (!misaligned) state_d = EMIT;
      EMIT:    if (out_valid && out_ready && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake/status outputs decode the state directly.
  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
  end

  // Datapath: alignment countdown, beat loading and beat retirement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q     <= '0;
      res_q     <= 2'b00;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      residual  <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rem_q <= in_data;
            res_q <= 2'b00;
          end
        end
        ALIGN: begin
          if (misaligned) begin
            rem_q <= rem_q - ONE_W;
            res_q <= res_q + 2'd1;
          end else begin
            out_data  <= beat_data;
            out_last  <= beat_last;
            out_valid <= 1'b1;
            residual  <= res_q;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (!out_last) begin
              // Retire the current beat and present the next one on the same edge.
              rem_q     <= rem_sub;
              out_data  <= beat_data;
              out_last  <= beat_last;
              out_valid <= 1'b1;
              residual  <= res_q;
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMO_SPLIT_ASSERT_EN
  logic [WIDTH-1:0] chk_sum_q;
  logic [WIDTH-1:0] chk_total_q;

  // Track the aligned total and the running sum of handshaken beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_sum_q   <= '0;
      chk_total_q <= '0;
    end else if ((state_q == IDLE) && in_valid) begin
      chk_sum_q   <= '0;
      chk_total_q <= in_data & {{(WIDTH-2){1'b1}}, ~ALIGN_MASK};
    end else if (out_valid && out_ready) begin
      chk_sum_q   <= chk_sum_q + out_data;
    end
  end

  a_beat_shape : assert property (@(posedge clk) disable iff (!reset)
    out_valid |-> ((out_data[1:0] == 2'b00) && (out_data <= CHUNK_W)));

  a_stall_hold : assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_data) && $stable(out_last) && $stable(residual)));

  a_state_legal : assert property (@(posedge clk) disable iff (!reset)
    (state_q inside {IDLE, ALIGN, EMIT}));

  a_sum_matches : assert property (@(posedge clk) disable iff (!reset)
    (out_valid && out_ready && out_last) |-> ((chk_sum_q + out_data) == chk_total_q));
`endif

endmodule

// File: tb/tb_demo_split.sv
// tb/tb_demo_split.sv - scoreboard bench for demo_split
module tb_demo_split;

  localparam int WIDTH = 8;
  localparam int CHUNK = 16;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic [1:0]       res;
  } beat_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       residual;
  logic             busy;

  beat_t sb[$];
  int    n_cmp;
  int    n_err;

  demo_split #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .residual  (residual),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: expected beat list for one total.
  task automatic push_model(input int total);
    int    left;
    int    b;
    beat_t e;
    left = total - (total % 4);
    if (left == 0) begin
      e.data = '0; e.last = 1'b1; e.res = 2'(total % 4);
      sb.push_back(e);
    end else begin
      while (left > 0) begin
        b    = (left > CHUNK) ? CHUNK : left;
        left = left - b;
        e.data = WIDTH'(b); e.last = (left == 0); e.res = 2'(total % 4);
        sb.push_back(e);
      end
    end
  endtask

  // Compare every handshaken beat against the scoreboard.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("extra_beat", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat_data", 32'(out_data), 32'(e.data));
        check("beat_last", 32'(out_last), 32'(e.last));
        check("beat_residual", 32'(residual), 32'(e.res));
      end
    end
  end

  // Wait for IDLE, then present one total; returns just after the accepting edge.
  task automatic accept(input int total);
    int n;
    n = 0;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("accept_wait", 32'(n < 500), 32'd1);
    in_valid = 1'b1;
    in_data  = WIDTH'(total);
    push_model(total);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int lat;
    int n;
    int bad;
    n_cmp = 0; n_err = 0;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_residual", 32'(residual), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 6: three align cycles, single beat of 4 with residual 2
    accept(6);
    check("t6_busy", 32'(busy), 32'd1);
    wait_out_valid(lat);
    check("t6_latency", 32'(lat), 32'd3);
    check("t6_last", 32'(out_last), 32'd1);
    @(posedge clk); #1;
    check("t6_busy_drop", 32'(busy), 32'd0);
    check("t6_valid_drop", 32'(out_valid), 32'd0);
    wait_idle(50);

    // 40: already aligned, back-to-back beats 16,16,8
    accept(40);
    wait_out_valid(lat);
    check("t40_latency", 32'(lat), 32'd1);
    n = 1;
    while (!out_last && n < 20) begin
      @(posedge clk); #1;
      if (out_valid) n++;
      else n = 100;
    end
    check("t40_beats_consecutive", 32'(n), 32'd3);
    wait_idle(50);

    // zero-aligned totals
    accept(0);
    wait_out_valid(lat);
    check("t0_latency", 32'(lat), 32'd1);
    wait_idle(50);
    accept(3);
    wait_out_valid(lat);
    check("t3_latency", 32'(lat), 32'd4);
    wait_idle(50);

    // 255 with a 5-cycle stall on the first beat
    out_ready = 1'b0;
    accept(255);
    wait_out_valid(lat);
    check("t255_latency", 32'(lat), 32'd4);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== WIDTH'(16) || residual !== 2'd3 || out_last !== 1'b0) bad++;
    end
    check("t255_stall_hold", 32'(bad), 32'd0);
    out_ready = 1'b1;
    wait_idle(100);

    // async reset during beat 2 of 40
    accept(40);
    wait_out_valid(lat);
    @(posedge clk); #1;
    check("rst_mid_beat2", 32'(out_data), 32'd16);
    reset = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_after_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_after_valid", 32'(out_valid), 32'd0);
    accept(4);
    wait_out_valid(lat);
    check("t4_latency", 32'(lat), 32'd1);
    wait_idle(50);

    // in_valid held with 100 during the split of 40
    in_valid = 1'b1;
    in_data  = WIDTH'(40);
    push_model(40);
    @(posedge clk); #1;
    in_data = WIDTH'(100);
    bad = 0;
    n = 0;
    while (!(out_valid && out_ready && out_last) && n < 50) begin
      if (in_ready) bad++;
      @(posedge clk); #1; n++;
    end
    check("hold_ignored", 32'(bad), 32'd0);
    check("hold_last_seen", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    check("hold_ready_after_last", 32'(in_ready), 32'd1);
    push_model(100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold_accepted", 32'(busy), 32'd1);
    wait_idle(100);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
